// File: rtl/matrix_loader_pkg.sv
// Shared constants and FSM state type for the matrix loader and the feeder it drives.
package matrix_loader_pkg;

   localparam int unsigned NUM_ELEMS  = 4;
   localparam int unsigned LAST_CYCLE = 5;

   // Window of compute_cycles values during which output_sel steps through results.
   localparam int unsigned SEL_FIRST  = 2;
   localparam int unsigned SEL_LAST   = 5;

   typedef enum logic {
      StLoad    = 1'b0,
      StCompute = 1'b1
   } state_t;

endpackage

// File: rtl/matrix_loader.sv
// Byte-serial loader for the weight and input banks, plus the compute-pass sequencer
// that drives en / compute_cycles / output_sel into the feeder.
module matrix_loader #(
   parameter int unsigned NUM_ELEMS  = matrix_loader_pkg::NUM_ELEMS,
   parameter int unsigned LAST_CYCLE = matrix_loader_pkg::LAST_CYCLE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_valid,
   input  logic [7:0]             load_data,
   output logic                   load_ready,
   output logic [8*NUM_ELEMS-1:0] weights,
   output logic [8*NUM_ELEMS-1:0] inputs,
   output logic                   en,
   output logic [2:0]             compute_cycles,
   output logic [1:0]             output_sel,
   output logic                   busy,
   output logic [7:0]             pass_count
);
   import matrix_loader_pkg::*;

   localparam int unsigned PTR_W = $clog2(2 * NUM_ELEMS);
   localparam int unsigned IDX_W = PTR_W - 1;

   state_t                        state_q, state_d;
   logic [PTR_W-1:0]              ptr_q;
   logic [NUM_ELEMS-1:0][7:0]     weights_q;
   logic [NUM_ELEMS-1:0][7:0]     inputs_q;
   logic [2:0]                    cycles_q;
   logic [7:0]                    pass_q;

   logic                          accept;
   logic                          last_byte;
   logic                          last_cycle;
   logic [IDX_W-1:0]              idx;

   assign accept     = load_valid && (state_q == StLoad);
   assign last_byte  = (ptr_q == PTR_W'(2 * NUM_ELEMS - 1));
   assign last_cycle = (state_q == StCompute) && (cycles_q == 3'(LAST_CYCLE));
   // Top pointer bit picks the bank, the rest picks the element.
   assign idx        = ptr_q[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:    if (accept && last_byte) state_d = StCompute;
         StCompute: if (last_cycle)          state_d = StLoad;
         default:                            state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         weights_q <= '0;
         inputs_q  <= '0;
      end else if (accept) begin
         ptr_q <= ptr_q + PTR_W'(1);
         if (ptr_q[PTR_W-1]) begin
            inputs_q[idx] <= load_data;
         end else begin
            weights_q[idx] <= load_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles_q <= '0;
         pass_q   <= '0;
      end else if (state_q == StCompute) begin
         if (last_cycle) begin
            cycles_q <= '0;
            pass_q   <= pass_q + 8'd1;
         end else begin
            cycles_q <= cycles_q + 3'd1;
         end
      end else begin
         cycles_q <= '0;
      end
   end

   always_comb begin
      output_sel = 2'd0;
      if (cycles_q >= 3'(SEL_FIRST) && cycles_q <= 3'(SEL_LAST)) begin
         output_sel = 2'(cycles_q - 3'(SEL_FIRST));
      end
   end

   assign load_ready     = (state_q == StLoad);
   assign en             = (state_q == StCompute);
   assign busy           = (state_q == StCompute);
   assign compute_cycles = cycles_q;
   assign pass_count     = pass_q;
   assign weights        = weights_q;
   assign inputs         = inputs_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: full and gapped loads, compute sequencing,
// async reset mid-pass and pass_count wrap.
module tb_matrix_loader;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic [31:0] weights;
   logic [31:0] inputs;
   logic        en;
   logic [2:0]  compute_cycles;
   logic [1:0]  output_sel;
   logic        busy;
   logic [7:0]  pass_count;

   int checks = 0;
   int errors = 0;

   matrix_loader dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_valid     (load_valid),
      .load_data      (load_data),
      .load_ready     (load_ready),
      .weights        (weights),
      .inputs         (inputs),
      .en             (en),
      .compute_cycles (compute_cycles),
      .output_sel     (output_sel),
      .busy           (busy),
      .pass_count     (pass_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   initial begin
      logic [1:0] sel_tbl [6];
      sel_tbl = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      #1;
      check("rst_ready", load_ready, 1);
      check("rst_en", en, 0);
      check("rst_busy", busy, 0);
      check("rst_weights", weights, 0);
      check("rst_pass", pass_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full back-to-back load of 1..8.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = 8'(i + 1);
         if (i == 7) check("ready_before_last", load_ready, 1);
      end
      @(negedge clk);
      // Keep hammering 0xFF during compute; it must be ignored.
      load_data = 8'hFF;
      check("full_weights", weights, 32'h04030201);
      check("full_inputs", inputs, 32'h08070605);
      check("full_en", en, 1);
      check("full_ready", load_ready, 0);
      for (int k = 0; k < 6; k++) begin
         check("cc", compute_cycles, 64'(k));
         check("sel", output_sel, sel_tbl[k]);
         check("busy", busy, 1);
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("end_en", en, 0);
      check("end_ready", load_ready, 1);
      check("end_cc", compute_cycles, 0);
      check("end_pass", pass_count, 1);
      check("ignored_weights", weights, 32'h04030201);
      check("ignored_inputs", inputs, 32'h08070605);

      // Gapped load of 0x11..0x18, junk data on idle cycles.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = 8'(8'h11 + i);
         @(negedge clk);
         load_valid = 1'b0;
         load_data  = 8'hEE;
         if (i == 6) begin
            check("gap_no_compute", en, 0);
            check("gap_mix_weights", weights, 32'h14131211);
            check("gap_mix_inputs", inputs, 32'h08171615);
         end
      end
      check("gap_en", en, 1);
      check("gap_cc", compute_cycles, 0);
      check("gap_weights", weights, 32'h14131211);
      check("gap_inputs", inputs, 32'h18171615);
      repeat (6) @(negedge clk);
      check("gap_pass", pass_count, 2);
      check("gap_ready", load_ready, 1);

      // Async reset in the middle of a pass.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = 8'(8'h31 + i);
      end
      @(negedge clk);
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_cc", compute_cycles, 3);
      #1 rst_n = 1'b0;
      #1;
      check("arst_en", en, 0);
      check("arst_busy", busy, 0);
      check("arst_cc", compute_cycles, 0);
      check("arst_sel", output_sel, 0);
      check("arst_weights", weights, 0);
      check("arst_inputs", inputs, 0);
      check("arst_pass", pass_count, 0);
      check("arst_ready", load_ready, 1);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = 8'(8'hA0 + i);
      end
      @(negedge clk);
      load_valid = 1'b0;
      check("post_rst_inputs", inputs, 32'hA7A6A5A4);
      repeat (6) @(negedge clk);
      check("post_rst_pass", pass_count, 1);

      // Back-to-back passes: each one is 8 load cycles plus 6 compute cycles.
      load_valid = 1'b1;
      load_data  = 8'h5A;
      repeat (254 * 14) @(negedge clk);
      check("pass_255", pass_count, 255);
      check("pass_255_ready", load_ready, 1);
      repeat (14) @(negedge clk);
      check("pass_wrap", pass_count, 0);
      load_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
